// File: rtl/or1200_ic_fsm.sv
// Instruction-cache control FSM: tag lookup/compare, burst line refill,
// single-line invalidate and bus-error recovery around a flop-based tag RAM.
module or1200_ic_fsm #(
  parameter int ADDR_W     = 32,
  parameter int IDX_W      = 8,
  parameter int LINE_WORDS = 4,
  localparam int OFF_W     = $clog2(LINE_WORDS),
  localparam int TAG_W     = ADDR_W - IDX_W - OFF_W - 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_req_i,
  input  logic [ADDR_W-1:0]      cpu_adr_i,
  output logic                   cpu_ack_o,
  output logic                   cpu_err_o,
  input  logic                   inv_req_i,
  input  logic [ADDR_W-1:0]      inv_adr_i,
  output logic                   inv_ack_o,
  output logic                   tag_ce_o,
  output logic                   tag_we_o,
  output logic [IDX_W-1:0]       tag_addr_o,
  output logic [TAG_W:0]         tag_di_o,
  input  logic [TAG_W:0]         tag_doq_i,
  output logic                   bus_cyc_o,
  output logic [ADDR_W-1:0]      bus_adr_o,
  input  logic                   bus_ack_i,
  input  logic                   bus_err_i,
  output logic                   dram_we_o,
  output logic [IDX_W+OFF_W-1:0] dram_addr_o
);

  localparam int LINE_W = ADDR_W - OFF_W - 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COMPARE = 3'd1,
    REFILL  = 3'd2,
    TAGWR   = 3'd3,
    ERRINV  = 3'd4,
    INV     = 3'd5
  } state_t;

  state_t            state, state_nxt;
  // Only the line address (tag + index) of the fetch is kept.
  logic [LINE_W-1:0] adr_q, adr_nxt;
  logic [OFF_W-1:0]  beat, beat_nxt;

  logic [TAG_W-1:0]  tag_q;
  logic [IDX_W-1:0]  idx_q, idx_cpu, idx_inv;
  logic              hit, last_beat;
  logic              unused_bits;

  assign tag_q     = adr_q[LINE_W-1 -: TAG_W];
  assign idx_q     = adr_q[IDX_W-1:0];
  assign idx_cpu   = cpu_adr_i[IDX_W+OFF_W+1:OFF_W+2];
  assign idx_inv   = inv_adr_i[IDX_W+OFF_W+1:OFF_W+2];
  assign hit       = tag_doq_i[0] & (tag_doq_i[TAG_W:1] == tag_q);
  assign last_beat = (beat == OFF_W'(LINE_WORDS - 1));

  assign unused_bits = ^{cpu_adr_i[OFF_W+1:0], inv_adr_i[OFF_W+1:0],
                         inv_adr_i[ADDR_W-1:IDX_W+OFF_W+2]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      adr_q <= '0;
      beat  <= '0;
    end else begin
      state <= state_nxt;
      adr_q <= adr_nxt;
      beat  <= beat_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    adr_nxt     = adr_q;
    beat_nxt    = beat;
    cpu_ack_o   = 1'b0;
    cpu_err_o   = 1'b0;
    inv_ack_o   = 1'b0;
    tag_ce_o    = 1'b0;
    tag_we_o    = 1'b0;
    tag_addr_o  = '0;
    tag_di_o    = '0;
    bus_cyc_o   = 1'b0;
    bus_adr_o   = '0;
    dram_we_o   = 1'b0;
    dram_addr_o = '0;

    case (state)
      IDLE: begin
        // Gated by rst so every output is quiet while reset is held.
        if (!rst) begin
          if (inv_req_i) begin
            state_nxt = INV;
          end else if (cpu_req_i) begin
            tag_ce_o   = 1'b1;
            tag_addr_o = idx_cpu;
            adr_nxt    = cpu_adr_i[ADDR_W-1:OFF_W+2];
            state_nxt  = COMPARE;
          end
        end
      end

      COMPARE: begin
        tag_ce_o   = 1'b1;
        tag_addr_o = idx_q;
        if (hit) begin
          cpu_ack_o = 1'b1;
          state_nxt = IDLE;
        end else begin
          beat_nxt  = '0;
          state_nxt = REFILL;
        end
      end

      REFILL: begin
        bus_cyc_o   = 1'b1;
        bus_adr_o   = {tag_q, idx_q, beat, 2'b00};
        dram_addr_o = {idx_q, beat};
        if (bus_err_i) begin
          state_nxt = ERRINV;
        end else if (bus_ack_i) begin
          dram_we_o = 1'b1;
          beat_nxt  = beat + OFF_W'(1);
          if (last_beat) state_nxt = TAGWR;
        end
      end

      TAGWR: begin
        tag_ce_o   = 1'b1;
        tag_we_o   = 1'b1;
        tag_addr_o = idx_q;
        tag_di_o   = {tag_q, 1'b1};
        cpu_ack_o  = 1'b1;
        state_nxt  = IDLE;
      end

      // Partially refilled line: clear the valid bit so it can never hit.
      ERRINV: begin
        tag_ce_o   = 1'b1;
        tag_we_o   = 1'b1;
        tag_addr_o = idx_q;
        cpu_err_o  = 1'b1;
        state_nxt  = IDLE;
      end

      INV: begin
        tag_ce_o   = 1'b1;
        tag_we_o   = 1'b1;
        tag_addr_o = idx_inv;
        inv_ack_o  = 1'b1;
        state_nxt  = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_or1200_ic_fsm.sv
// Directed bench for or1200_ic_fsm with a behavioural flop tag RAM.
module tb_or1200_ic_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req_i;
  logic [31:0] cpu_adr_i;
  logic        cpu_ack_o, cpu_err_o;
  logic        inv_req_i;
  logic [31:0] inv_adr_i;
  logic        inv_ack_o;
  logic        tag_ce_o, tag_we_o;
  logic [7:0]  tag_addr_o;
  logic [20:0] tag_di_o;
  logic [20:0] tag_doq_i;
  logic        bus_cyc_o;
  logic [31:0] bus_adr_o;
  logic        bus_ack_i, bus_err_i;
  logic        dram_we_o;
  logic [9:0]  dram_addr_o;

  int n_chk  = 0;
  int n_fail = 0;

  logic [20:0] mem [256];

  or1200_ic_fsm dut (
    .clk(clk), .rst(rst),
    .cpu_req_i(cpu_req_i), .cpu_adr_i(cpu_adr_i),
    .cpu_ack_o(cpu_ack_o), .cpu_err_o(cpu_err_o),
    .inv_req_i(inv_req_i), .inv_adr_i(inv_adr_i), .inv_ack_o(inv_ack_o),
    .tag_ce_o(tag_ce_o), .tag_we_o(tag_we_o), .tag_addr_o(tag_addr_o),
    .tag_di_o(tag_di_o), .tag_doq_i(tag_doq_i),
    .bus_cyc_o(bus_cyc_o), .bus_adr_o(bus_adr_o),
    .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i),
    .dram_we_o(dram_we_o), .dram_addr_o(dram_addr_o)
  );

  always #5 clk = ~clk;

  // Flop tag RAM: read data reflects last cycle's index, 0 when ce was low.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    tag_doq_i = '0;
  end
  always @(posedge clk) begin
    if (tag_ce_o && tag_we_o) mem[tag_addr_o] <= tag_di_o;
    tag_doq_i <= tag_ce_o ? mem[tag_addr_o] : '0;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full line refill from base, one beat per cycle; ends at the start of TAGWR.
  task automatic refill(input logic [31:0] base);
    for (int b = 0; b < 4; b++) begin
      bus_ack_i = 1'b1;
      #1;
      chk("refill_cyc", 32'(bus_cyc_o), 32'd1);
      chk("refill_adr", bus_adr_o, base + 32'(4 * b));
      chk("refill_we", 32'(dram_we_o), 32'd1);
      chk("refill_daddr", 32'(dram_addr_o), ((base >> 2) & 32'h3FC) | 32'(b));
      nxt();
    end
    bus_ack_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cpu_req_i = 1'b0; cpu_adr_i = '0;
    inv_req_i = 1'b0; inv_adr_i = '0; bus_ack_i = 1'b0; bus_err_i = 1'b0;
    nxt(); nxt();
    cpu_req_i = 1'b1; cpu_adr_i = 32'h0000_1040;
    #1;
    chk("rst_ce", 32'(tag_ce_o), 32'd0);
    chk("rst_cyc", 32'(bus_cyc_o), 32'd0);
    chk("rst_ack", 32'(cpu_ack_o), 32'd0);
    chk("rst_inv_ack", 32'(inv_ack_o), 32'd0);
    chk("rst_dwe", 32'(dram_we_o), 32'd0);
    cpu_req_i = 1'b0; rst = 1'b0;
    nxt();

    // Cold miss on 0x1040
    cpu_req_i = 1'b1; cpu_adr_i = 32'h0000_1040;
    #1;
    chk("t1_ce", 32'(tag_ce_o), 32'd1);
    chk("t1_we", 32'(tag_we_o), 32'd0);
    chk("t1_addr", 32'(tag_addr_o), 32'h04);
    nxt();
    cpu_adr_i = 32'hDEAD_0000;
    #1;
    chk("t1_cmp_ce", 32'(tag_ce_o), 32'd1);
    chk("t1_cmp_addr", 32'(tag_addr_o), 32'h04);
    chk("t1_cmp_ack", 32'(cpu_ack_o), 32'd0);
    nxt();
    #1;
    chk("t1_wait_cyc", 32'(bus_cyc_o), 32'd1);
    chk("t1_wait_adr", bus_adr_o, 32'h0000_1040);
    chk("t1_wait_dwe", 32'(dram_we_o), 32'd0);
    nxt();
    refill(32'h0000_1040);
    #1;
    chk("t1_tw_we", 32'(tag_we_o), 32'd1);
    chk("t1_tw_addr", 32'(tag_addr_o), 32'h04);
    chk("t1_tw_di", 32'(tag_di_o), 32'h0000_0003);
    chk("t1_tw_ack", 32'(cpu_ack_o), 32'd1);
    chk("t1_tw_cyc", 32'(bus_cyc_o), 32'd0);
    nxt();
    cpu_req_i = 1'b0;
    #1;
    chk("t1_idle_ack", 32'(cpu_ack_o), 32'd0);
    chk("t1_mem", 32'(mem[4]), 32'h0000_0003);
    nxt();

    // Hit on 0x1048
    cpu_req_i = 1'b1; cpu_adr_i = 32'h0000_1048;
    #1;
    chk("t2_acc_ack", 32'(cpu_ack_o), 32'd0);
    nxt();
    #1;
    chk("t2_hit_ack", 32'(cpu_ack_o), 32'd1);
    chk("t2_hit_cyc", 32'(bus_cyc_o), 32'd0);
    nxt();
    cpu_req_i = 1'b0;
    #1;
    chk("t2_after_ack", 32'(cpu_ack_o), 32'd0);
    chk("t2_after_cyc", 32'(bus_cyc_o), 32'd0);
    nxt();

    // Same index, different tag: conflict miss
    cpu_req_i = 1'b1; cpu_adr_i = 32'h0010_1040;
    nxt();
    #1;
    chk("t3_cmp_ack", 32'(cpu_ack_o), 32'd0);
    nxt();
    refill(32'h0010_1040);
    #1;
    chk("t3_tw_di", 32'(tag_di_o), 32'h0000_0203);
    chk("t3_tw_ack", 32'(cpu_ack_o), 32'd1);
    nxt();
    cpu_req_i = 1'b0;
    #1;
    chk("t3_mem", 32'(mem[4]), 32'h0000_0203);
    nxt();

    // Invalidate wins over a simultaneous fetch
    inv_req_i = 1'b1; inv_adr_i = 32'h0010_1040;
    cpu_req_i = 1'b1; cpu_adr_i = 32'h0010_1040;
    #1;
    chk("t5_idle_ce", 32'(tag_ce_o), 32'd0);
    nxt();
    #1;
    chk("t5_inv_ack", 32'(inv_ack_o), 32'd1);
    chk("t5_inv_we", 32'(tag_we_o), 32'd1);
    chk("t5_inv_addr", 32'(tag_addr_o), 32'h04);
    chk("t5_inv_di", 32'(tag_di_o), 32'd0);
    chk("t5_inv_cack", 32'(cpu_ack_o), 32'd0);
    nxt();
    inv_req_i = 1'b0;
    #1;
    chk("t5_mem", 32'(mem[4]), 32'd0);
    chk("t5_acc_ce", 32'(tag_ce_o), 32'd1);
    chk("t5_acc_inv_ack", 32'(inv_ack_o), 32'd0);
    nxt();
    #1;
    chk("t5_miss_ack", 32'(cpu_ack_o), 32'd0);
    nxt();
    refill(32'h0010_1040);
    nxt();
    cpu_req_i = 1'b0;
    nxt();

    // Bus error on beat 2
    cpu_req_i = 1'b1; cpu_adr_i = 32'h0000_2040;
    nxt();
    nxt();
    bus_ack_i = 1'b1;
    #1;
    chk("t4_b0_dwe", 32'(dram_we_o), 32'd1);
    nxt();
    #1;
    chk("t4_b1_dwe", 32'(dram_we_o), 32'd1);
    nxt();
    bus_err_i = 1'b1;
    #1;
    chk("t4_b2_adr", bus_adr_o, 32'h0000_2048);
    chk("t4_b2_dwe", 32'(dram_we_o), 32'd0);
    nxt();
    bus_ack_i = 1'b0; bus_err_i = 1'b0;
    #1;
    chk("t4_err", 32'(cpu_err_o), 32'd1);
    chk("t4_err_ack", 32'(cpu_ack_o), 32'd0);
    chk("t4_err_we", 32'(tag_we_o), 32'd1);
    chk("t4_err_di", 32'(tag_di_o), 32'd0);
    chk("t4_err_addr", 32'(tag_addr_o), 32'h04);
    chk("t4_err_cyc", 32'(bus_cyc_o), 32'd0);
    nxt();
    cpu_req_i = 1'b0;
    #1;
    chk("t4_err_gone", 32'(cpu_err_o), 32'd0);
    chk("t4_mem", 32'(mem[4]), 32'd0);
    nxt();

    // Refetch misses; reset during beat 1
    cpu_req_i = 1'b1;
    nxt();
    #1;
    chk("t6_miss_ack", 32'(cpu_ack_o), 32'd0);
    nxt();
    bus_ack_i = 1'b1;
    #1;
    chk("t6_b0_adr", bus_adr_o, 32'h0000_2040);
    nxt();
    #1;
    chk("t6_b1_adr", bus_adr_o, 32'h0000_2044);
    chk("t6_b1_dwe", 32'(dram_we_o), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_cyc", 32'(bus_cyc_o), 32'd0);
    chk("t6_rst_dwe", 32'(dram_we_o), 32'd0);
    chk("t6_rst_ack", 32'(cpu_ack_o), 32'd0);
    chk("t6_rst_ce", 32'(tag_ce_o), 32'd0);
    nxt();
    rst = 1'b0; cpu_req_i = 1'b0; bus_ack_i = 1'b0;
    nxt();
    cpu_req_i = 1'b1; cpu_adr_i = 32'h0000_1040;
    #1;
    chk("t6_acc_ce", 32'(tag_ce_o), 32'd1);
    nxt();
    #1;
    chk("t6_cmp_ack", 32'(cpu_ack_o), 32'd0);
    nxt();
    #1;
    chk("t6_ref_cyc", 32'(bus_cyc_o), 32'd1);
    chk("t6_ref_adr", bus_adr_o, 32'h0000_1040);
    chk("t6_ref_daddr", 32'(dram_addr_o), 32'h10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
